// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Sequencer around an external bit-serial adder. A pair of WIDTH-bit operands
// is accepted over a valid/ready handshake and shifted out LSB-first on
// ser_a / ser_b. The adder's sum bits are shifted back in and its final
// carry is captured. The parallel result is then offered over a second
// valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_a, in_b          operands, sampled only on the accepting edge
//   ser_en              a bit is presented to the adder this cycle
//   ser_start           first bit of an operation (adder carry-in = 0)
//   ser_a, ser_b        current operand bits (0 when ser_en is low)
//   ser_sum, ser_cy     adder sum / carry-out for the current bit
//   out_valid/out_ready result handshake; held stable until accepted
//   out_sum, out_cy     (in_a + in_b) mod 2^WIDTH and the MSB carry-out
// ---------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_en,
    output logic             ser_start,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum,
    input  logic             ser_cy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
    // Separate result register so out_sum holds its last value while
    // sum_sh is busy collecting bits of the next operation.
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             cy_q,      cy_d;
    logic [CW-1:0]    cnt_q,     cnt_d;

    logic             shifting;
    logic [WIDTH-1:0] sum_in;

    assign shifting = (state_q == SHIFT);
    // Incoming sum bit lands in the MSB; after WIDTH shifts bit 0 is the LSB.
    assign sum_in   = {ser_sum, sum_sh_q[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_cy    = cy_q;

    // Serial outputs are gated so they read 0 whenever no bit is presented.
    assign ser_en    = shifting;
    assign ser_start = shifting && (cnt_q == '0);
    assign ser_a     = shifting && a_sh_q[0];
    assign ser_b     = shifting && b_sh_q[0];

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        out_sum_d = out_sum_q;
        cy_d      = cy_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_in;
                if (cnt_q == LAST) begin
                    // Last bit: capture final carry and the completed sum;
                    // the counter stays at LAST rather than wrapping.
                    cy_d      = ser_cy;
                    out_sum_d = sum_in;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            out_sum_q <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            out_sum_q <= out_sum_d;
            cy_q      <= cy_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//
// Two instances: WIDTH=4 for directed vectors (bit-level serial checks,
// latency, backpressure hold, reset mid-operation) and WIDTH=8 for a random
// regression. Each instance is fed by a behavioural serial adder. Stimulus
// pushes hand-computed results into a scoreboard queue; monitor processes
// sample on the falling edge and pop/compare on every result handshake.
// Inputs are driven 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ WIDTH=4
    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_cy4;
    logic [3:0] in_a4 = '0, in_b4 = '0, out_sum4;
    logic       ser_en4, ser_start4, ser_a4, ser_b4, ser_sum4, ser_cy4, cin4;
    logic       c4 = 1'b0;

    assign cin4     = ser_start4 ? 1'b0 : c4;
    assign ser_sum4 = ser_a4 ^ ser_b4 ^ cin4;
    assign ser_cy4  = (ser_a4 & ser_b4) | (ser_a4 & cin4) | (ser_b4 & cin4);
    always @(posedge clk) if (ser_en4) c4 <= ser_cy4;

    serial_add_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
        .ser_en(ser_en4), .ser_start(ser_start4), .ser_a(ser_a4), .ser_b(ser_b4),
        .ser_sum(ser_sum4), .ser_cy(ser_cy4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_cy(out_cy4)
    );

    // ------------------------------------------------------------ WIDTH=8
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, out_cy8;
    logic [7:0] in_a8 = '0, in_b8 = '0, out_sum8;
    logic       ser_en8, ser_start8, ser_a8, ser_b8, ser_sum8, ser_cy8, cin8;
    logic       c8 = 1'b0;

    assign cin8     = ser_start8 ? 1'b0 : c8;
    assign ser_sum8 = ser_a8 ^ ser_b8 ^ cin8;
    assign ser_cy8  = (ser_a8 & ser_b8) | (ser_a8 & cin8) | (ser_b8 & cin8);
    always @(posedge clk) if (ser_en8) c8 <= ser_cy8;

    serial_add_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
        .ser_en(ser_en8), .ser_start(ser_start8), .ser_a(ser_a8), .ser_b(ser_b8),
        .ser_sum(ser_sum8), .ser_cy(ser_cy8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8), .out_cy(out_cy8)
    );

    // ------------------------------------------------------------ scoreboards
    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];
    int         acc4_q[$];

    // Monitor for WIDTH=4: serial bits, latency, hold under backpressure, results.
    initial begin : mon4
        logic [3:0] cur_a4, cur_b4, hold_sum4;
        logic       hold_cy4, ov_prev4;
        int         k4;
        logic [4:0] e4;
        cur_a4 = '0; cur_b4 = '0; hold_sum4 = '0; hold_cy4 = 1'b0; ov_prev4 = 1'b0; k4 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc4_q.delete();
                ov_prev4 = 1'b0;
            end else begin
                if (ser_en4) begin
                    chk("ser_start4", 32'(ser_start4), 32'(k4 == 0));
                    chk("ser_a4", 32'(ser_a4), 32'(cur_a4[k4[1:0]]));
                    chk("ser_b4", 32'(ser_b4), 32'(cur_b4[k4[1:0]]));
                    k4++;
                end else begin
                    chk("ser_idle_zero4", 32'({ser_start4, ser_a4, ser_b4}), 32'd0);
                end
                if (out_valid4) begin
                    chk("in_ready_done4", 32'(in_ready4), 32'd0);
                    if (!ov_prev4) begin
                        chk("ser_cycles4", 32'(k4), 32'd4);
                        if (acc4_q.size() > 0)
                            chk("latency4", 32'(cyc - acc4_q.pop_front()), 32'd5);
                        else
                            chk("latency_no_accept4", 32'(acc4_q.size()), 32'd1);
                    end else begin
                        chk("hold_sum4", 32'(out_sum4), 32'(hold_sum4));
                        chk("hold_cy4", 32'(out_cy4), 32'(hold_cy4));
                    end
                    hold_sum4 = out_sum4;
                    hold_cy4  = out_cy4;
                    if (out_ready4) begin
                        if (exp4_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_result4: got 0x%0h with empty scoreboard", {out_cy4, out_sum4});
                        end else begin
                            e4 = exp4_q.pop_front();
                            chk("result4", 32'({out_cy4, out_sum4}), 32'(e4));
                            $display("W4 result {cy,sum}=0x%0h expected 0x%0h", {out_cy4, out_sum4}, e4);
                        end
                    end
                end
                ov_prev4 = out_valid4 && !out_ready4;
                if (in_valid4 && in_ready4) begin
                    cur_a4 = in_a4;
                    cur_b4 = in_b4;
                    k4     = 0;
                    acc4_q.push_back(cyc);
                end
            end
        end
    end

    // Monitor for WIDTH=8: serial bits and results.
    initial begin : mon8
        logic [7:0] cur_a8, cur_b8;
        int         k8;
        logic [8:0] e8;
        cur_a8 = '0; cur_b8 = '0; k8 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ser_en8) begin
                    chk("ser_start8", 32'(ser_start8), 32'(k8 == 0));
                    chk("ser_a8", 32'(ser_a8), 32'(cur_a8[k8[2:0]]));
                    chk("ser_b8", 32'(ser_b8), 32'(cur_b8[k8[2:0]]));
                    k8++;
                end
                if (out_valid8 && out_ready8) begin
                    if (exp8_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result8: got 0x%0h with empty scoreboard", {out_cy8, out_sum8});
                    end else begin
                        e8 = exp8_q.pop_front();
                        chk("result8", 32'({out_cy8, out_sum8}), 32'(e8));
                    end
                end
                if (in_valid8 && in_ready8) begin
                    cur_a8 = in_a8;
                    cur_b8 = in_b8;
                    k8     = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp, output int waits);
        in_a4 = a; in_b4 = b; in_valid4 = 1'b1; waits = 0;
        do begin @(negedge clk); waits++; end while (!in_ready4 && waits < 200);
        if (!in_ready4) begin
            checks++; errors++;
            $display("FAIL accept_timeout4: in_ready stuck at 0 for %0d cycles", waits);
        end else begin
            exp4_q.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int waits;
        in_a8 = a; in_b8 = b; in_valid8 = 1'b1; waits = 0;
        do begin @(negedge clk); waits++; end while (!in_ready8 && waits < 500);
        if (!in_ready8) begin
            checks++; errors++;
            $display("FAIL accept_timeout8: in_ready stuck at 0 for %0d cycles", waits);
        end else begin
            exp8_q.push_back({1'b0, a} + {1'b0, b});
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while ((exp4_q.size() != 0 || out_valid4) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout4: %0d results still pending", exp4_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_chk4(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready4),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid4), 32'd0);
        chk({tag, "_out_sum"},   32'(out_sum4),   32'd0);
        chk({tag, "_out_cy"},    32'(out_cy4),    32'd0);
        chk({tag, "_ser"},       32'({ser_en4, ser_start4, ser_a4, ser_b4}), 32'd0);
    endtask

    // Random backpressure for the WIDTH=8 instance.
    initial begin : rdy8
        forever begin
            @(posedge clk); #1;
            out_ready8 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        int w;
        int n;
        #1;
        reset_chk4("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic and back-to-back operations, out_ready tied high.
        send4(4'h3, 4'h5, 5'h08, w);
        send4(4'h9, 4'h8, 5'h11, w);
        send4(4'hF, 4'hF, 5'h1E, w);
        send4(4'h0, 4'h0, 5'h00, w);
        drain4();

        // Backpressure: hold result while new operands wait.
        out_ready4 = 1'b0;
        send4(4'h1, 4'h2, 5'h03, w);
        n = 0;
        while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
        chk("bp_out_valid_seen", 32'(out_valid4), 32'd1);
        @(posedge clk); #1;
        in_a4 = 4'h4; in_b4 = 4'h4; in_valid4 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready4), 32'd0);
            chk("bp_out_valid", 32'(out_valid4), 32'd1);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        send4(4'h4, 4'h4, 5'h08, w);
        chk("bp_accept_edge", 32'(w), 32'd2);
        drain4();

        // Reset during the second SHIFT cycle of 0x7+0x7.
        in_a4 = 4'h7; in_b4 = 4'h7; in_valid4 = 1'b1;
        @(negedge clk);
        chk("rst_op_accept", 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #2;
        chk("rst_op_in_shift", 32'(ser_en4), 32'd1);
        rst = 1'b1;
        #1;
        reset_chk4("midrst");
        @(posedge clk); #1;
        reset_chk4("midrst_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        send4(4'h2, 4'h1, 5'h03, w);
        drain4();
        chk("rst_no_residue_valid", 32'(out_valid4), 32'd0);

        // Random regression on WIDTH=8.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send8(8'($urandom), 8'($urandom));
        end
        n = 0;
        while ((exp8_q.size() != 0 || out_valid8) && n < 2000) begin @(negedge clk); n++; end
        chk("drain8_pending", 32'(exp8_q.size()), 32'd0);
        chk("final_queue4", 32'(exp4_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
